csr_access_sequencer: RTL and testbench

Front-end controller for the per-core CSR data block's single read port and single write port. It accepts CSR instructions from the issue pipeline and, optionally, a debug requester. It arbitrates between them round-robin and runs each access as an atomic read-then-modify-write sequence (CSRRW/CSRRS/CSRRC semantics). The old CSR value is returned on a response handshake. It sits between the CSR unit's request queue and the CSR data block.

---
 rtl/csr_access_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// CSR access sequencer: arbitrates CSR requests and runs each as an atomic read-then-modify-write
// with the old value returned on a response handshake. Optional debug requester: CSR_DBG_PORT_EN.
module csr_access_sequencer #(
  parameter int ADDR_W = 12,
  parameter int WID_W  = 2,
  parameter int UUID_W = 44,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WID_W-1:0]  req_wid,
  input  logic [UUID_W-1:0] req_uuid,
  input  logic [DATA_W-1:0] req_data,

`ifdef CSR_DBG_PORT_EN
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [1:0]        dbg_req_op,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [WID_W-1:0]  dbg_req_wid,
  input  logic [UUID_W-1:0] dbg_req_uuid,
  input  logic [DATA_W-1:0] dbg_req_data,
`endif

  output logic              read_enable,
  output logic [ADDR_W-1:0] read_addr,
  output logic [WID_W-1:0]  read_wid,
  output logic [UUID_W-1:0] read_uuid,
  input  logic [DATA_W-1:0] read_data,

  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WID_W-1:0]  write_wid,
  output logic [UUID_W-1:0] write_uuid,
  output logic [DATA_W-1:0] write_data,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [DATA_W-1:0] rsp_data,
  output logic [WID_W-1:0]  rsp_wid,
  output logic [UUID_W-1:0] rsp_uuid,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [WID_W-1:0]    r_wid;
  logic [UUID_W-1:0]   r_uuid;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_old;
  logic [DATA_W-1:0]   r_new;

  logic                w_idle_ok;
  logic                w_any_valid;
  logic                w_accept;
  logic                w_wr_suppress;
  logic [DATA_W-1:0]   w_new;
  logic [1:0]          w_sel_op;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [WID_W-1:0]    w_sel_wid;
  logic [UUID_W-1:0]   w_sel_uuid;
  logic [DATA_W-1:0]   w_sel_data;

  // Nothing is granted while reset is high, so no request can be lost to a reset edge.
  assign w_idle_ok = (r_state == S_IDLE) && !reset;
  assign w_accept  = w_idle_ok && w_any_valid;

`ifdef CSR_DBG_PORT_EN
  logic r_last_dbg;
  logic r_src;
  logic w_sel_dbg;

  // Debug wins when it is the only requester or when the pipeline was granted last.
  assign w_sel_dbg   = dbg_req_valid && (!req_valid || !r_last_dbg);
  assign w_any_valid = req_valid || dbg_req_valid;

  assign w_sel_op    = w_sel_dbg ? dbg_req_op   : req_op;
  assign w_sel_addr  = w_sel_dbg ? dbg_req_addr : req_addr;
  assign w_sel_wid   = w_sel_dbg ? dbg_req_wid  : req_wid;
  assign w_sel_uuid  = w_sel_dbg ? dbg_req_uuid : req_uuid;
  assign w_sel_data  = w_sel_dbg ? dbg_req_data : req_data;

  assign req_ready     = w_idle_ok && req_valid && !w_sel_dbg;
  assign dbg_req_ready = w_idle_ok && w_sel_dbg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_dbg <= 1'b1;
      r_src      <= 1'b0;
    end else if (w_accept) begin
      r_last_dbg <= w_sel_dbg;
      r_src      <= w_sel_dbg;
    end
  end

  assign rsp_src = r_src;
`else
  assign w_any_valid = req_valid;

  assign w_sel_op    = req_op;
  assign w_sel_addr  = req_addr;
  assign w_sel_wid   = req_wid;
  assign w_sel_uuid  = req_uuid;
  assign w_sel_data  = req_data;

  assign req_ready   = w_idle_ok && req_valid;
  assign rsp_src     = 1'b0;
`endif

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_new         = r_data;
    w_wr_suppress = 1'b0;
    case (r_op)
      OP_RW: begin
        w_new = r_data;
      end
      OP_RS: begin
        w_new         = read_data | r_data;
        w_wr_suppress = (r_data == '0);
      end
      OP_RC: begin
        w_new         = read_data & ~r_data;
        w_wr_suppress = (r_data == '0);
      end
      default: begin
        w_new         = read_data;
        w_wr_suppress = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_READ;
      end
      S_READ: begin
        read_enable = 1'b1;
        w_state_nxt = w_wr_suppress ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        // A reset arriving in this cycle must keep the write from landing.
        write_enable = !reset;
        w_state_nxt  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = !reset;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments only; reset is synchronous and
  // also clears the holding register so every address/data output reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_addr <= '0;
      r_wid  <= '0;
      r_uuid <= '0;
      r_data <= '0;
      r_old  <= '0;
      r_new  <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= w_sel_op;
        r_addr <= w_sel_addr;
        r_wid  <= w_sel_wid;
        r_uuid <= w_sel_uuid;
        r_data <= w_sel_data;
      end
      if (r_state == S_READ) begin
        r_old <= read_data;
        r_new <= w_new;
      end
    end
  end

  assign read_addr  = r_addr;
  assign read_wid   = r_wid;
  assign read_uuid  = r_uuid;

  assign write_addr = r_addr;
  assign write_wid  = r_wid;
  assign write_uuid = r_uuid;
  assign write_data = r_new;

  assign rsp_data   = r_old;
  assign rsp_wid    = r_wid;
  assign rsp_uuid   = r_uuid;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer: vector table of single accesses plus hand-written
// backpressure, reset-abort and (with CSR_DBG_PORT_EN) round-robin sequences.
module tb_csr_access_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [1:0]  req_wid;
  logic [43:0] req_uuid;
  logic [31:0] req_data;
`ifdef CSR_DBG_PORT_EN
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic [1:0]  dbg_req_op;
  logic [11:0] dbg_req_addr;
  logic [1:0]  dbg_req_wid;
  logic [43:0] dbg_req_uuid;
  logic [31:0] dbg_req_data;
`endif
  logic        read_enable;
  logic [11:0] read_addr;
  logic [1:0]  read_wid;
  logic [43:0] read_uuid;
  logic [31:0] read_data;
  logic        write_enable;
  logic [11:0] write_addr;
  logic [1:0]  write_wid;
  logic [43:0] write_uuid;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_src;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_wid;
  logic [43:0] rsp_uuid;
  logic        busy;

  logic [31:0] csr_mem [0:4095];
  int          rd_total;
  int          wr_total;
  int          n_tests;
  int          n_fail;

  csr_access_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wid      (req_wid),
    .req_uuid     (req_uuid),
    .req_data     (req_data),
`ifdef CSR_DBG_PORT_EN
    .dbg_req_valid(dbg_req_valid),
    .dbg_req_ready(dbg_req_ready),
    .dbg_req_op   (dbg_req_op),
    .dbg_req_addr (dbg_req_addr),
    .dbg_req_wid  (dbg_req_wid),
    .dbg_req_uuid (dbg_req_uuid),
    .dbg_req_data (dbg_req_data),
`endif
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_wid     (read_wid),
    .read_uuid    (read_uuid),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_wid    (write_wid),
    .write_uuid   (write_uuid),
    .write_data   (write_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_src      (rsp_src),
    .rsp_data     (rsp_data),
    .rsp_wid      (rsp_wid),
    .rsp_uuid     (rsp_uuid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR data block model: combinational read from preloaded contents.
  assign read_data = csr_mem[read_addr];

  always @(posedge clk) begin
    if (read_enable)  rd_total <= rd_total + 1;
    if (write_enable) wr_total <= wr_total + 1;
  end

  initial begin
    rd_total = 0;
    wr_total = 0;
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] init;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                           input logic [1:0] wid, input logic [43:0] uuid);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_wid   = wid;
    req_uuid  = uuid;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [43:0] uuid;
    logic [1:0]  wid;
    int          rd0;
    int          wr0;
    uuid = 44'h0A5_0000_0000 + 44'(idx);
    wid  = 2'(idx);
    csr_mem[v.addr] = v.init;
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), busy, 0);
    check($sformatf("v%0d_idle_rsp_valid", idx), rsp_valid, 0);
    check($sformatf("v%0d_idle_wr_en", idx), write_enable, 0);
    rd0 = rd_total;
    wr0 = wr_total;
    rsp_ready = 1'b1;
    drive_req(v.op, v.addr, v.data, wid, uuid);
    #1;
    check($sformatf("v%0d_req_ready", idx), req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_rd_en", idx), read_enable, 1);
    check($sformatf("v%0d_rd_addr", idx), read_addr, v.addr);
    check($sformatf("v%0d_rd_wid", idx), read_wid, wid);
    check($sformatf("v%0d_rd_uuid", idx), read_uuid, uuid);
    check($sformatf("v%0d_c1_wr_en", idx), write_enable, 0);
    check($sformatf("v%0d_c1_rsp_valid", idx), rsp_valid, 0);
    @(negedge clk);
    if (v.exp_wr) begin
      check($sformatf("v%0d_wr_en", idx), write_enable, 1);
      check($sformatf("v%0d_wr_data", idx), write_data, v.exp_wdata);
      check($sformatf("v%0d_wr_addr", idx), write_addr, v.addr);
      check($sformatf("v%0d_wr_uuid", idx), write_uuid, uuid);
      check($sformatf("v%0d_c2_rd_en", idx), read_enable, 0);
      check($sformatf("v%0d_c2_rsp_valid", idx), rsp_valid, 0);
      @(negedge clk);
    end else begin
      check($sformatf("v%0d_no_wr_en", idx), write_enable, 0);
    end
    check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
    check($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_rsp);
    check($sformatf("v%0d_rsp_wid", idx), rsp_wid, wid);
    check($sformatf("v%0d_rsp_uuid", idx), rsp_uuid, uuid);
    check($sformatf("v%0d_rsp_src", idx), rsp_src, 0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_read_pulses", idx), rd_total - rd0, 1);
    check($sformatf("v%0d_write_pulses", idx), wr_total - wr0, v.exp_wr ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_snap;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;

    vecs[0] = '{2'b00, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b1, 32'h0000_0008, 32'h0000_1888};
    vecs[1] = '{2'b01, 12'hB00, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h1234_5678};
    vecs[2] = '{2'b10, 12'h001, 32'h0000_0005, 32'h0000_001F, 1'b1, 32'h0000_001A, 32'h0000_001F};
    vecs[3] = '{2'b01, 12'h304, 32'h0000_0808, 32'h0000_0080, 1'b1, 32'h0000_0888, 32'h0000_0080};
    vecs[4] = '{2'b11, 12'hF14, 32'h0000_FFFF, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'h0000_0003};
    vecs[5] = '{2'b10, 12'h344, 32'h0000_0000, 32'h0000_AAAA, 1'b0, 32'h0000_0000, 32'h0000_AAAA};
    vecs[6] = '{2'b00, 12'h340, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[7] = '{2'b10, 12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};

    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wid   = '0;
    req_uuid  = '0;
    req_data  = '0;
`ifdef CSR_DBG_PORT_EN
    dbg_req_valid = 1'b0;
    dbg_req_op    = 2'b00;
    dbg_req_addr  = '0;
    dbg_req_wid   = '0;
    dbg_req_uuid  = '0;
    dbg_req_data  = '0;
`endif

    // Reset values, sampled while reset is still held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_en", read_enable, 0);
    check("rst_wr_en", write_enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_addr", read_addr, 0);
    check("rst_rd_uuid", read_uuid, 0);
    check("rst_wr_data", write_data, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_uuid", rsp_uuid, 0);
    check("rst_rsp_src", rsp_src, 0);
`ifdef CSR_DBG_PORT_EN
    check("rst_dbg_ready", dbg_req_ready, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Response backpressure: rsp_ready low for 5 RESP cycles with a second request waiting.
    csr_mem[12'h7C0] = 32'h0BAD_F00D;
    csr_mem[12'hC00] = 32'h0000_0055;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(2'b00, 12'h7C0, 32'h0000_0001, 2'd1, 44'h0BB_0000_0001);
    #1;
    check("bp_accept", req_ready, 1);
    @(posedge clk);
    #1 drive_req(2'b11, 12'hC00, 32'h0, 2'd2, 44'h0BB_0000_0002);
    @(negedge clk);
    check("bp_c1_ready", req_ready, 0);
    @(negedge clk);
    check("bp_wr_data", write_data, 32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("bp_stall%0d_rsp_data", i), rsp_data, 32'h0BAD_F00D);
      check($sformatf("bp_stall%0d_rsp_uuid", i), rsp_uuid, 44'h0BB_0000_0001);
      check($sformatf("bp_stall%0d_req_ready", i), req_ready, 0);
      check($sformatf("bp_stall%0d_rd_en", i), read_enable, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_rsp_valid", rsp_valid, 1);
    check("bp_hs_req_ready", req_ready, 0);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_rd_en", read_enable, 1);
    check("bp_next_rd_addr", read_addr, 12'hC00);
    check("bp_next_rd_uuid", read_uuid, 44'h0BB_0000_0002);
    @(negedge clk);
    check("bp_next_rsp_valid", rsp_valid, 1);
    check("bp_next_rsp_data", rsp_data, 32'h0000_0055);
    check("bp_next_rsp_wid", rsp_wid, 2'd2);
    @(posedge clk);
    #1;

    // Reset during WRITE: the write is dropped and the block is idle right after.
    csr_mem[12'h301] = 32'h0000_00FF;
    @(negedge clk);
    drive_req(2'b00, 12'h301, 32'h0000_1234, 2'd3, 44'h0CC_0000_0001);
    #1;
    check("rw_abort_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wr_snap = wr_total;
    @(negedge clk);
    check("rw_abort_rd_en", read_enable, 1);
    @(negedge clk);
    check("rw_abort_in_write", write_enable, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rw_abort_no_write", wr_total - wr_snap, 0);
    run_vec(vecs[2], 9);

`ifdef CSR_DBG_PORT_EN
    // Both requesters valid continuously: grants alternate starting with the pipeline.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    csr_mem[12'h100] = 32'h0000_0011;
    csr_mem[12'h200] = 32'h0000_0022;
    drive_req(2'b11, 12'h100, 32'h0, 2'd0, 44'h0DD_0000_0000);
    dbg_req_valid = 1'b1;
    dbg_req_op    = 2'b11;
    dbg_req_addr  = 12'h200;
    dbg_req_wid   = 2'd1;
    dbg_req_uuid  = 44'h0DD_0000_0001;
    dbg_req_data  = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_pipe_ready", k), req_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_dbg_ready", k), dbg_req_ready, (k % 2 == 1) ? 1 : 0);
      @(negedge clk);
      check($sformatf("rr%0d_rd_addr", k), read_addr, (k % 2 == 0) ? 12'h100 : 12'h200);
      @(negedge clk);
      check($sformatf("rr%0d_rsp_valid", k), rsp_valid, 1);
      check($sformatf("rr%0d_rsp_src", k), rsp_src, (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d_rsp_data", k), rsp_data, (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    req_valid     = 1'b0;
    dbg_req_valid = 1'b0;
    @(posedge clk);
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
